// File: rtl/basys3_io_pkg.sv
// Shared constants and types for the Basys3 pushbutton/switch input stage.
//   - default sizes and timing constants (100 MHz clock)
//   - repeat FSM state type
//   - bit positions inside step_pulse
//   - helper to size a down-to-zero timer
package basys3_io_pkg;

    localparam int unsigned WIDTH_DEFAULT           = 16;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;   // 10 ms
    localparam int unsigned REPEAT_DELAY_DEFAULT    = 50_000_000;  // 0.5 s
    localparam int unsigned REPEAT_PERIOD_DEFAULT   = 10_000_000;  // 0.1 s

    typedef enum logic [1:0] {
        RptIdle,
        RptHeld,
        RptRepeat
    } rpt_state_e;

    // step_pulse = {load, clear, down, up}
    localparam int unsigned STEP_UP    = 0;
    localparam int unsigned STEP_DOWN  = 1;
    localparam int unsigned STEP_CLEAR = 2;
    localparam int unsigned STEP_LOAD  = 3;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchroniser, debouncer and press detector for one raw pushbutton.
//   clk    in  system clock
//   rst_n  in  asynchronous reset, active low
//   raw    in  pushbutton pin, asynchronous to clk, active high
//   level  out debounced level; changes only after DEBOUNCE_CYCLES stable cycles
//   press  out one-cycle pulse on the rising edge of level
module btn_debounce
    import basys3_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int unsigned     TW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0]   TimerMax = TW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1, sync_q2;
    logic          level_q, level_d;
    logic          prev_q;
    logic [TW-1:0] timer_q, timer_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            timer_q <= '0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            level_q <= level_d;
            prev_q  <= level_q;
            timer_q <= timer_d;
        end
    end

    // Timer runs only while the synchronised input disagrees with the accepted
    // level; any agreeing cycle restarts the count, so glitches are dropped.
    always_comb begin
        timer_d = '0;
        level_d = level_q;
        if (sync_q2 != level_q) begin
            if (timer_q == TimerMax) begin
                level_d = ~level_q;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    assign level = level_q;
    assign press = level_q & ~prev_q;

endmodule

// File: rtl/basys3_button_counter.sv
// Pushbutton/switch input stage for the Basys3 LED demos.
// Debounces four buttons, auto-repeats up/down while held, and keeps a
// modulo-2^WIDTH counter that drives the LEDs.
//   clk         in  100 MHz system clock
//   rst_n       in  asynchronous reset, active low
//   btn_up      in  raw pushbutton, count +1 (repeats while held)
//   btn_down    in  raw pushbutton, count -1 (repeats while held)
//   btn_clear   in  raw pushbutton, count <= 0
//   btn_load    in  raw pushbutton, count <= sw
//   sw          in  slide switches (load value), synchronised only
//   count       out counter value
//   step_pulse  out {load, clear, down, up} one-cycle event pulses
module basys3_button_counter
    import basys3_io_pkg::*;
#(
    parameter int unsigned WIDTH           = WIDTH_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_clear,
    input  logic             btn_load,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] count,
    output logic [3:0]       step_pulse
);

    localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                    : REPEAT_PERIOD;
    localparam int unsigned    RTW       = cnt_width(RptMax);
    localparam logic [RTW-1:0] DelayMax  = RTW'(REPEAT_DELAY - 1);
    localparam logic [RTW-1:0] PeriodMax = RTW'(REPEAT_PERIOD - 1);

    logic [3:0]       btn_raw;
    logic [3:0]       btn_level;
    logic [3:0]       btn_press;
    logic [1:0]       rpt_step;
    logic [WIDTH-1:0] sw_q1, sw_q2;
    logic [WIDTH-1:0] count_q, count_d;
    logic             unused_level;

    assign btn_raw = {btn_load, btn_clear, btn_down, btn_up};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn_debounce (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (btn_raw[i]),
            .level(btn_level[i]),
            .press(btn_press[i])
        );
    end

    // Clear and load act on the press only; their held level is not needed.
    assign unused_level = ^btn_level[3:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_q1 <= '0;
            sw_q2 <= '0;
        end else begin
            sw_q1 <= sw;
            sw_q2 <= sw_q1;
        end
    end

    // Hold-to-repeat for up (index 0) and down (index 1).
    for (genvar i = 0; i < 2; i++) begin : g_rpt
        rpt_state_e     state_q, state_d;
        logic [RTW-1:0] timer_q, timer_d;
        logic           step;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= RptIdle;
                timer_q <= '0;
            end else begin
                state_q <= state_d;
                timer_q <= timer_d;
            end
        end

        always_comb begin
            state_d = state_q;
            timer_d = '0;
            step    = 1'b0;
            unique case (state_q)
                RptIdle: begin
                    if (btn_press[i]) begin
                        step    = 1'b1;
                        state_d = RptHeld;
                    end
                end
                RptHeld: begin
                    if (!btn_level[i]) begin
                        state_d = RptIdle;
                    end else if (timer_q == DelayMax) begin
                        step    = 1'b1;
                        state_d = RptRepeat;
                    end else begin
                        timer_d = timer_q + RTW'(1);
                    end
                end
                RptRepeat: begin
                    if (!btn_level[i]) begin
                        state_d = RptIdle;
                    end else if (timer_q == PeriodMax) begin
                        step = 1'b1;
                    end else begin
                        timer_d = timer_q + RTW'(1);
                    end
                end
                default: state_d = RptIdle;
            endcase
        end

        assign rpt_step[i] = step;
    end

    assign step_pulse = {btn_press[STEP_LOAD], btn_press[STEP_CLEAR], rpt_step[1], rpt_step[0]};

    always_comb begin
        count_d = count_q;
        if (step_pulse[STEP_CLEAR]) begin
            count_d = '0;
        end else if (step_pulse[STEP_LOAD]) begin
            count_d = sw_q2;
        end else if (step_pulse[STEP_UP] && step_pulse[STEP_DOWN]) begin
            count_d = count_q;
        end else if (step_pulse[STEP_UP]) begin
            count_d = count_q + WIDTH'(1);
        end else if (step_pulse[STEP_DOWN]) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_basys3_button_counter.sv
module tb_basys3_button_counter;

    localparam int W   = 4;
    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         btn_up = 1'b0, btn_down = 1'b0, btn_clear = 1'b0, btn_load = 1'b0;
    logic [W-1:0] sw = '0;
    logic [W-1:0] count;
    logic [3:0]   step_pulse;

    int checks = 0;
    int failures = 0;

    basys3_button_counter #(
        .WIDTH(W), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
        .btn_clear(btn_clear), .btn_load(btn_load), .sw(sw),
        .count(count), .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;

    // Reference model: each button's last DEB synchronised samples, how long
    // up/down have been held since their press, and the counter value.
    logic         m_s1 [4];
    logic         m_s2 [4];
    logic         m_lvl [4];
    logic         m_lvlq [4];
    logic         m_hist [4][DEB];
    int           m_since [2];
    logic [W-1:0] m_sw1, m_sw2, m_count;
    logic [3:0]   m_step;

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_lvlq[b] = 0;
            for (int j = 0; j < DEB; j++) m_hist[b][j] = 0;
        end
        m_since[0] = -1; m_since[1] = -1;
        m_sw1 = '0; m_sw2 = '0; m_count = '0; m_step = '0;
    endtask

    task automatic model_edge();
        logic [3:0]   raw;
        logic [W-1:0] nc;
        logic         all_diff;
        nc = m_count;
        if (m_step[2]) nc = '0;
        else if (m_step[3]) nc = m_sw2;
        else if (m_step[0] && m_step[1]) nc = m_count;
        else if (m_step[0]) nc = m_count + 1'b1;
        else if (m_step[1]) nc = m_count - 1'b1;
        raw = {btn_load, btn_clear, btn_down, btn_up};
        for (int b = 0; b < 4; b++) begin
            m_lvlq[b] = m_lvl[b];
            for (int j = DEB - 1; j > 0; j--) m_hist[b][j] = m_hist[b][j-1];
            m_hist[b][0] = m_s2[b];
            all_diff = 1;
            for (int j = 0; j < DEB; j++) if (m_hist[b][j] == m_lvl[b]) all_diff = 0;
            if (all_diff) m_lvl[b] = ~m_lvl[b];
            m_s2[b] = m_s1[b];
            m_s1[b] = raw[b];
        end
        m_sw2 = m_sw1; m_sw1 = sw; m_count = nc;
        for (int b = 0; b < 2; b++) begin
            if (!m_lvl[b]) m_since[b] = -1;
            else if (!m_lvlq[b]) m_since[b] = 0;
            else if (m_since[b] >= 0) m_since[b]++;
            m_step[b] = (m_since[b] == 0) || (m_since[b] == RD) ||
                        (m_since[b] > RD && ((m_since[b] - RD) % RP) == 0);
        end
        m_step[2] = m_lvl[2] & ~m_lvlq[2];
        m_step[3] = m_lvl[3] & ~m_lvlq[3];
    endtask

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
        end
    endtask

    // One clock: advance the model at the edge, compare #1 later.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        else model_reset();
        #1;
        chk("model_count", count, m_count);
        chk("model_step", step_pulse, m_step);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_btns(input logic [3:0] m);
        {btn_load, btn_clear, btn_down, btn_up} = m;
    endtask

    task automatic press(input logic [3:0] m, input int hold);
        set_btns(m);
        ticks(hold);
        set_btns(4'b0000);
        ticks(12);
    endtask

    int          offs [$];
    int          first;
    logic [3:0]  seen;
    logic [3:0]  mask;
    int          exp_offs [6] = '{0, 20, 28, 36, 44, 52};

    initial begin
        model_reset();
        #1;
        chk("reset_count", count, 4'h0);
        chk("reset_step", step_pulse, 4'h0);
        ticks(3);
        rst_n = 1'b1;
        ticks(2);

        // 1: single press, exact latency
        btn_up = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 6) begin
                chk("lat_step", step_pulse, 4'b0001);
                chk("lat_count_before", count, 4'h0);
            end
            if (k == 7) chk("lat_count_after", count, 4'h1);
        end
        btn_up = 1'b0;
        ticks(15);
        chk("single_press_count", count, 4'h1);

        // 2: glitch shorter than the debounce window
        seen = '0;
        btn_up = 1'b1;
        for (int k = 0; k < 3; k++) begin tick(); seen |= step_pulse; end
        btn_up = 1'b0;
        for (int k = 0; k < 12; k++) begin tick(); seen |= step_pulse; end
        chk("glitch_steps", seen, 4'h0);
        chk("glitch_count", count, 4'h1);

        // 3: wrap both ways
        press(4'b0100, 6);
        chk("clear_count", count, 4'h0);
        press(4'b0010, 6);
        chk("wrap_down", count, 4'hF);
        for (int i = 0; i < 16; i++) press(4'b0001, 6);
        chk("wrap_up16", count, 4'hF);

        // 4: hold-to-repeat timing
        press(4'b0100, 6);
        offs.delete();
        first = -1;
        btn_up = 1'b1;
        for (int k = 0; k < 80; k++) begin
            if (k == 60) btn_up = 1'b0;
            tick();
            if (step_pulse[0]) begin
                if (first < 0) first = k;
                offs.push_back(k - first);
            end
        end
        chk_int("repeat_nsteps", offs.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < offs.size()) chk_int("repeat_offset", offs[i], exp_offs[i]);
        chk("repeat_count", count, 4'h6);

        // 5: load, clear beats up, up+down cancel
        sw = 4'hA;
        ticks(3);
        press(4'b1000, 6);
        chk("load_count", count, 4'hA);
        press(4'b0101, 6);
        chk("clear_over_up", count, 4'h0);
        press(4'b0001, 6);
        chk("up_one", count, 4'h1);
        press(4'b0011, 6);
        chk("up_down_cancel", count, 4'h1);

        // 6: reset while repeating
        btn_up = 1'b1;
        ticks(35);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_reset_count", count, 4'h0);
        chk("async_reset_step", step_pulse, 4'h0);
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 6) chk("rst_fresh_step", step_pulse, 4'b0001);
            if (k == 6) chk("rst_fresh_before", count, 4'h0);
            if (k == 7) chk("rst_fresh_after", count, 4'h1);
        end
        btn_up = 1'b0;
        ticks(15);

        // Randomised: arbitrary button combinations, hold times and switches
        for (int it = 0; it < 60; it++) begin
            sw = W'($urandom_range(0, 15));
            mask = 4'($urandom_range(0, 15));
            set_btns(mask);
            ticks($urandom_range(1, 45));
            set_btns(4'b0000);
            ticks($urandom_range(0, 14));
        end
        ticks(15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
